pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_decode.sv | 60 ++++++
 rtl/pipe_control.sv | 124 ++++++++++++
 tb/tb_pipe_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode map, control encodings and scoreboard types for the ID-stage
// pipeline controller (pipe_control / pipe_decode).
package pipe_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_R_FIRST = 8'h01;
  localparam logic [7:0] OP_R_LAST  = 8'h09;
  localparam logic [7:0] OP_I_FIRST = 8'h11;
  localparam logic [7:0] OP_I_LAST  = 8'h19;
  localparam logic [7:0] OP_LW      = 8'h20;
  localparam logic [7:0] OP_SW      = 8'h21;
  localparam logic [7:0] OP_JAL     = 8'h30;
  localparam logic [7:0] OP_J       = 8'h31;

  localparam logic [3:0] ALU_ADD    = 4'b0000;

  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  localparam logic [1:0] MTR_MEM    = 2'b00;
  localparam logic [1:0] MTR_ALU    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam int SB_DEPTH = 3;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_src;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic {
    SLOT_NORMAL = 1'b0,
    SLOT_SQUASH = 1'b1
  } slot_state_t;

endpackage

// File: rtl/pipe_decode.sv
// Combinational opcode decode: datapath controls, illegal-opcode detect and
// which source registers the instruction reads.
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [7:0] op,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (op >= OP_R_FIRST && op <= OP_R_LAST) begin
      ctrl.alu_op     = op[3:0] - 4'd1;
      ctrl.alu_src    = ALUSRC_REG;
      ctrl.mem_to_reg = MTR_ALU;
      ctrl.reg_write  = 1'b1;
      use_rs1         = 1'b1;
      use_rs2         = 1'b1;
    end else if (op >= OP_I_FIRST && op <= OP_I_LAST) begin
      ctrl.alu_op     = op[3:0] - 4'd1;
      ctrl.alu_src    = ALUSRC_IMM;
      ctrl.mem_to_reg = MTR_ALU;
      ctrl.reg_write  = 1'b1;
      use_rs1         = 1'b1;
    end else begin
      case (op)
        OP_NOP: illegal = 1'b0;
        OP_LW: begin
          ctrl.alu_op     = ALU_ADD;
          ctrl.alu_src    = ALUSRC_IMM;
          ctrl.mem_to_reg = MTR_MEM;
          ctrl.mem_read   = 1'b1;
          ctrl.reg_write  = 1'b1;
          use_rs1         = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_op    = ALU_ADD;
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.mem_write = 1'b1;
          use_rs1        = 1'b1;
          use_rs2        = 1'b1;
        end
        OP_JAL: begin
          ctrl.pc_src     = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = MTR_PC;
        end
        OP_J:    ctrl.pc_src = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_control.sv
// ID-stage pipeline controller: decode, RAW scoreboard stall, jump squash.
// Optional stall/flush statistics counters under PIPE_CONTROL_STATS_EN.
//
// state       | meaning
// SLOT_NORMAL | decode slot issues normally (may stall on hazard)
// SLOT_SQUASH | slot follows an issued jump: forced bubble, hazards ignored
module pipe_control
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [3:0]  ALUOp,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        stall,
  output logic        illegal,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  ctrl_t       dec_ctrl;
  ctrl_t       out_ctrl;
  logic        dec_illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;
  logic        illegal_q;
  slot_state_t state;
  slot_state_t state_nxt;
  sb_entry_t   sb [SB_DEPTH];

  pipe_decode u_decode (
    .op      (op),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // r0 is tracked like any other register
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb[i].valid && ((use_rs1 && sb[i].rd == rs1) || (use_rs2 && sb[i].rd == rs2)))
        hazard = 1'b1;
    end
  end

  always_comb begin
    out_ctrl  = dec_ctrl;
    stall     = 1'b0;
    state_nxt = SLOT_NORMAL;
    if (reset) begin
      out_ctrl = '0;
    end else begin
      case (state)
        SLOT_SQUASH: out_ctrl = '0;
        default: begin
          if (hazard) begin
            stall              = 1'b1;
            out_ctrl.reg_write = 1'b0;
            out_ctrl.mem_read  = 1'b0;
            out_ctrl.mem_write = 1'b0;
            out_ctrl.pc_src    = 1'b0;
          end else if (dec_ctrl.pc_src) begin
            state_nxt = SLOT_SQUASH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SLOT_NORMAL;
      illegal_q <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      state <= state_nxt;
      sb[0] <= '{valid: out_ctrl.reg_write, rd: rd};
      for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
      if (dec_illegal) illegal_q <= 1'b1;
    end
  end

  assign ALUOp    = out_ctrl.alu_op;
  assign ALUSrc   = out_ctrl.alu_src;
  assign MemToReg = out_ctrl.mem_to_reg;
  assign MemRead  = out_ctrl.mem_read;
  assign MemWrite = out_ctrl.mem_write;
  assign RegWrite = out_ctrl.reg_write;
  assign PCSrc    = out_ctrl.pc_src;
  assign illegal  = illegal_q;

`ifdef PIPE_CONTROL_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (state == SLOT_SQUASH && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a register-busy model.
module tb_pipe_control;

  logic        clk;
  logic        reset;
  logic [7:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  ALUOp;
  logic [1:0]  ALUSrc, MemToReg;
  logic        MemRead, MemWrite, RegWrite, PCSrc, stall, illegal;
  logic [15:0] stall_cnt, flush_cnt;

`ifdef PIPE_CONTROL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pipe_control dut (
    .clk(clk), .reset(reset), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCSrc(PCSrc), .stall(stall),
    .illegal(illegal), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] mtr;
    logic       mr, mw, rw, pc, u1, u2, ill;
  } m_t;

  typedef struct {
    logic [7:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       stall;
    logic [3:0] alu_op;
    logic [1:0] alu_src, mtr;
    logic       mr, mw, rw, pc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // model: cycles until each register's pending write no longer blocks readers
  int busy [32];
  bit m_squash, m_illegal;
  int m_scnt, m_fcnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic m_t ref_decode(input logic [7:0] o);
    m_t d = '0;
    int v = int'(o);
    if (v >= 1 && v <= 9) begin
      d.alu_op = 4'(v - 1); d.mtr = 2'd1; d.rw = 1; d.u1 = 1; d.u2 = 1;
    end else if (v >= 17 && v <= 25) begin
      d.alu_op = 4'(v - 17); d.alu_src = 2'd1; d.mtr = 2'd1; d.rw = 1; d.u1 = 1;
    end else if (v == 32) begin
      d.alu_src = 2'd1; d.mr = 1; d.rw = 1; d.u1 = 1;
    end else if (v == 33) begin
      d.alu_src = 2'd1; d.mw = 1; d.u1 = 1; d.u2 = 1;
    end else if (v == 48) begin
      d.pc = 1; d.rw = 1; d.mtr = 2'd2;
    end else if (v == 49) begin
      d.pc = 1;
    end else if (v != 0) begin
      d.ill = 1;
    end
    return d;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) busy[r] = 0;
    m_squash = 0; m_illegal = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_cycle();
    m_t d, e;
    bit hz, es;
    d  = ref_decode(op);
    hz = (d.u1 && busy[rs1] > 0) || (d.u2 && busy[rs2] > 0);
    e  = d;
    es = 0;
    if (m_squash) e = '0;
    else if (hz) begin
      es = 1; e.rw = 0; e.mr = 0; e.mw = 0; e.pc = 0;
    end
    chk("stall", stall, es);
    chk("ALUOp", ALUOp, e.alu_op);
    chk("ALUSrc", ALUSrc, e.alu_src);
    chk("MemToReg", MemToReg, e.mtr);
    chk("MemRead", MemRead, e.mr);
    chk("MemWrite", MemWrite, e.mw);
    chk("RegWrite", RegWrite, e.rw);
    chk("PCSrc", PCSrc, e.pc);
    chk("illegal", illegal, m_illegal);
    chk("stall_cnt", stall_cnt, STATS ? m_scnt : 0);
    chk("flush_cnt", flush_cnt, STATS ? m_fcnt : 0);
    for (int r = 0; r < 32; r++) if (busy[r] > 0) busy[r]--;
    if (e.rw) busy[rd] = 3;
    if (d.ill) m_illegal = 1;
    if (es && m_scnt < 65535) m_scnt++;
    if (m_squash && m_fcnt < 65535) m_fcnt++;
    m_squash = e.pc;
  endtask

  task automatic cyc(input logic [7:0] o, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    op = o; rd = d; rs1 = s1; rs2 = s2;
    #1;
    model_cycle();
  endtask

  task automatic do_reset(input logic [7:0] o, input logic [4:0] s1);
    @(negedge clk);
    reset = 1; op = o; rd = 5'd1; rs1 = s1; rs2 = s1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_MemRead", MemRead, 0);
    chk("rst_MemWrite", MemWrite, 0);
    chk("rst_PCSrc", PCSrc, 0);
    chk("rst_ALUOp", ALUOp, 0);
    model_clear();
    @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic vec_t mk(input logic [7:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic st, input logic [3:0] ao,
                              input logic [1:0] as, input logic [1:0] mt, input logic mr,
                              input logic mw, input logic rw, input logic pc);
    vec_t v;
    v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.stall = st; v.alu_op = ao;
    v.alu_src = as; v.mtr = mt; v.mr = mr; v.mw = mw; v.rw = rw; v.pc = pc;
    return v;
  endfunction

  vec_t tab[$];
  logic [7:0] ill_ops [5] = '{8'h0A, 8'h10, 8'hFF, 8'h22, 8'h32};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; op = 0; rd = 0; rs1 = 0; rs2 = 0;
    model_clear();

    //       op     rd  rs1 rs2 st aluop src mtr mr mw rw pc
    tab.push_back(mk(8'h00, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h01, 31, 1, 2, 0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h05, 31, 1, 2, 0, 4, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h09, 31, 1, 2, 0, 8, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h11, 31, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h17, 31, 1, 2, 0, 6, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h19, 31, 1, 2, 0, 8, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h20, 31, 1, 2, 0, 0, 1, 0, 1, 0, 1, 0));
    tab.push_back(mk(8'h21, 31, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0));
    tab.push_back(mk(8'h30, 31, 1, 2, 0, 0, 0, 2, 0, 0, 1, 1));
    tab.push_back(mk(8'h00, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h31, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(8'h00, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h0A, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h10, 31, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    // R producer rd3, dependent stalls three cycles then issues
    tab.push_back(mk(8'h01,  3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'h01, 4, 3, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(8'h01,  4, 3, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    // LW rd5 then SW reading r5 via rs2
    tab.push_back(mk(8'h20,  5, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'h21, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h21,  0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0));
    // JAL after a writer of r7 named in rs1: no stall, immediate jump
    tab.push_back(mk(8'h01,  7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h30,  2, 7, 7, 0, 0, 0, 2, 0, 0, 1, 1));
    tab.push_back(mk(8'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // J then R: squashed slot
    tab.push_back(mk(8'h31,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(8'h01,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // squash hides a hazard; producer still blocks the following slot
    tab.push_back(mk(8'h01,  8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(8'h31,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(8'h01,  9, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(8'h01,  9, 8, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(8'h01,  9, 8, 0, 0, 0, 0, 1, 0, 0, 1, 0));

    do_reset(8'h01, 5'd0);
    foreach (tab[i]) begin
      cyc(tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2);
      chk("tab_stall", stall, tab[i].stall);
      chk("tab_ALUOp", ALUOp, tab[i].alu_op);
      chk("tab_ALUSrc", ALUSrc, tab[i].alu_src);
      chk("tab_MemToReg", MemToReg, tab[i].mtr);
      chk("tab_MemRead", MemRead, tab[i].mr);
      chk("tab_MemWrite", MemWrite, tab[i].mw);
      chk("tab_RegWrite", RegWrite, tab[i].rw);
      chk("tab_PCSrc", PCSrc, tab[i].pc);
    end

    // jump then squashed slot: one flush counted
    do_reset(8'h31, 5'd0);
    cyc(8'h31, 0, 0, 0);
    chk("j_PCSrc", PCSrc, 1);
    cyc(8'h01, 1, 0, 0);
    chk("j_bubble_RegWrite", RegWrite, 0);
    chk("j_bubble_stall", stall, 0);
    cyc(8'h00, 0, 0, 0);
    chk("j_flush_cnt", flush_cnt, STATS ? 1 : 0);

    // illegal opcode is sticky until reset
    do_reset(8'h00, 5'd0);
    cyc(8'hFF, 1, 0, 0);
    chk("ill_RegWrite", RegWrite, 0);
    chk("ill_MemRead", MemRead, 0);
    chk("ill_MemWrite", MemWrite, 0);
    chk("ill_PCSrc", PCSrc, 0);
    cyc(8'h00, 0, 0, 0);
    chk("ill_flag", illegal, 1);
    cyc(8'h00, 0, 0, 0);
    chk("ill_flag_held", illegal, 1);
    do_reset(8'h00, 5'd0);
    cyc(8'h00, 0, 0, 0);
    chk("ill_flag_cleared", illegal, 0);

    // reset in the middle of a stall drops the scoreboard
    cyc(8'h01, 3, 0, 0);
    cyc(8'h01, 4, 3, 0);
    chk("rst_mid_stall_pre", stall, 1);
    do_reset(8'h01, 5'd3);
    cyc(8'h01, 4, 3, 0);
    chk("post_rst_stall", stall, 0);
    chk("post_rst_RegWrite", RegWrite, 1);
    chk("post_rst_stall_cnt", stall_cnt, 0);
    chk("post_rst_flush_cnt", flush_cnt, 0);

    // reset in the middle of a squash
    cyc(8'h30, 2, 0, 0);
    do_reset(8'h01, 5'd0);
    cyc(8'h01, 6, 0, 0);
    chk("post_squash_rst_RegWrite", RegWrite, 1);

    // random traffic against the busy-register model
    for (int n = 0; n < 600; n++) begin
      logic [7:0] o;
      int sel = $urandom_range(0, 19);
      if (n % 97 == 96) do_reset(8'(($urandom_range(0, 1) != 0) ? 8'h01 : 8'h31), 5'($urandom_range(0, 7)));
      case (sel)
        0, 1:       o = 8'h00;
        2, 3, 4, 5: o = 8'(8'h01 + $urandom_range(0, 8));
        6, 7, 8:    o = 8'(8'h11 + $urandom_range(0, 8));
        9, 10, 11:  o = 8'h20;
        12, 13, 14: o = 8'h21;
        15, 16:     o = 8'h30;
        17, 18:     o = 8'h31;
        default:    o = ill_ops[$urandom_range(0, 4)];
      endcase
      cyc(o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
